// File: rtl/swd_seq_ctrl_if.sv
// swd_seq_ctrl_if: command handshake and serial-wire output bundle for swd_seq_ctrl
interface swd_seq_ctrl_if #(parameter int CNT_W = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             abort;
  logic             swdio_o;
  logic             swdio_oe;
  logic             swclk_en;
  logic             done;
  logic             err;
  modport master (output cmd_valid, cmd_op, cmd_cnt, abort,
                  input  cmd_ready, swdio_o, swdio_oe, swclk_en, done, err);
  modport slave  (input  cmd_valid, cmd_op, cmd_cnt, abort,
                  output cmd_ready, swdio_o, swdio_oe, swclk_en, done, err);
endinterface

// File: rtl/swd_seq_ctrl.sv
// swd_seq_ctrl: emits SWD line-reset, JTAG-to-SWD and idle bit sequences, one bit per sck cycle
module swd_seq_ctrl #(
    parameter int LR_LEN = 64,
    parameter int CNT_W  = 8
) (
    input logic         sck,
    input logic         rst,
    swd_seq_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, ONES1 = 3'd1, SEQ16 = 3'd2, ONES2 = 3'd3, ZEROS = 3'd4, DONE = 3'd5;
    localparam int MAXC = (LR_LEN > (2**CNT_W - 1)) ? LR_LEN : (2**CNT_W - 1);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [15:0] SEQ = 16'hE79E;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic          err_q;
    logic          accept;
    logic          last;
    logic [4:0]    idx;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign last          = cnt == CW'(1);
    // counter runs 16..1 through SEQ16, giving LSB-first bit index 0..15
    assign idx           = 5'd16 - cnt[4:0];
    assign bus.cmd_ready = (state == IDLE) && !bus.abort;
    assign bus.swdio_oe  = (state == ONES1) || (state == SEQ16) || (state == ONES2) || (state == ZEROS);
    assign bus.swdio_o   = (state == ONES1) || (state == ONES2) || ((state == SEQ16) && SEQ[idx[3:0]]);
    assign bus.swclk_en  = bus.swdio_oe;
    assign bus.done      = state == DONE;
    assign bus.err       = err_q;
    always_ff @(posedge sck) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (bus.cmd_op == 2'b11);
            if (state != IDLE && bus.abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        op_q <= bus.cmd_op;
                        if (!bus.cmd_op[1]) begin
                            state <= ONES1;
                            cnt   <= CW'(LR_LEN);
                        end else if (bus.cmd_op == 2'b10) begin
                            state <= (bus.cmd_cnt == '0) ? DONE : ZEROS;
                            cnt   <= CW'(bus.cmd_cnt);
                        end
                    end
                    ONES1: if (last) begin
                        state <= (op_q == 2'b01) ? SEQ16 : DONE;
                        cnt   <= (op_q == 2'b01) ? CW'(16) : '0;
                    end else cnt <= cnt - CW'(1);
                    SEQ16: if (last) begin
                        state <= ONES2;
                        cnt   <= CW'(LR_LEN);
                    end else cnt <= cnt - CW'(1);
                    ONES2: if (last) begin
                        state <= ZEROS;
                        cnt   <= CW'(2);
                    end else cnt <= cnt - CW'(1);
                    ZEROS: if (last) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else cnt <= cnt - CW'(1);
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_swd_seq_ctrl.sv
// tb_swd_seq_ctrl: directed self-checking bench for swd_seq_ctrl with default parameters
module tb_swd_seq_ctrl;
    logic sck = 1'b0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] pat = 16'hE79E;
    swd_seq_ctrl_if #(.CNT_W(8)) bus ();
    swd_seq_ctrl #(.LR_LEN(64), .CNT_W(8)) dut (.sck(sck), .rst(rst), .bus(bus));
    always #5 sck = ~sck;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic exp_bit(input int mode, input int i);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        if (i < 64) return 1'b1;
        if (i < 80) return pat[i-64];
        if (i < 144) return 1'b1;
        return 1'b0;
    endfunction
    task automatic issue(input logic [1:0] op, input logic [7:0] cnt);
        chk("ready_pre_issue", 8'(bus.cmd_ready), 8'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_cnt = cnt;
        @(negedge sck);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic run_bits(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("bit%0d_m%0d", i, mode), 8'({bus.swclk_en, bus.swdio_oe, bus.swdio_o}), 8'({2'b11, exp_bit(mode, i)}));
            @(negedge sck);
        end
    endtask
    task automatic fin();
        chk("done_cycle", 8'({bus.done, bus.swdio_oe, bus.swdio_o, bus.cmd_ready, bus.err}), 8'b10000);
        @(negedge sck);
        chk("after_done", 8'({bus.done, bus.swdio_oe, bus.cmd_ready}), 8'b001);
    endtask
    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_cnt = 8'd0;
        bus.abort = 1'b0;
        @(negedge sck);
        chk("reset_out", 8'({bus.swdio_o, bus.swdio_oe, bus.swclk_en, bus.done, bus.err}), 8'd0);
        bus.cmd_valid = 1'b1;
        @(negedge sck);
        chk("reset_hold", 8'({bus.swdio_o, bus.swdio_oe, bus.swclk_en, bus.done, bus.err}), 8'd0);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge sck);
        chk("ready_after_rst", 8'({bus.cmd_ready, bus.swdio_oe}), 8'b10);
        // LINE_RESET
        issue(2'b00, 8'd0);
        run_bits(64, 0);
        fin();
        // JTAG_TO_SWD
        issue(2'b01, 8'd0);
        run_bits(146, 1);
        fin();
        // IDLE(50) with inputs changed after acceptance
        issue(2'b10, 8'd50);
        bus.cmd_op = 2'b11;
        bus.cmd_cnt = 8'd3;
        run_bits(50, 2);
        fin();
        // IDLE(0)
        issue(2'b10, 8'd0);
        fin();
        // reserved op
        issue(2'b11, 8'd0);
        chk("err_pulse", 8'({bus.err, bus.swdio_oe, bus.done, bus.cmd_ready}), 8'b1001);
        @(negedge sck);
        chk("err_clear", 8'({bus.err, bus.swdio_oe, bus.done, bus.cmd_ready}), 8'b0001);
        // abort at bit 20 of JTAG_TO_SWD
        issue(2'b01, 8'd0);
        run_bits(20, 1);
        bus.abort = 1'b1;
        chk("bit20", 8'({bus.swdio_oe, bus.swdio_o}), 8'b11);
        @(negedge sck);
        chk("abort_out", 8'({bus.swdio_oe, bus.swdio_o, bus.done, bus.err, bus.cmd_ready}), 8'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'b00;
        @(negedge sck);
        chk("abort_no_accept", 8'({bus.swdio_oe, bus.done, bus.err, bus.cmd_ready}), 8'd0);
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b0;
        @(negedge sck);
        chk("abort_idle", 8'({bus.swdio_oe, bus.done, bus.cmd_ready}), 8'b001);
        // reset at bit 30 of LINE_RESET
        issue(2'b00, 8'd0);
        run_bits(30, 0);
        rst = 1'b1;
        bus.abort = 1'b1;
        bus.cmd_valid = 1'b1;
        @(negedge sck);
        chk("rst_mid", 8'({bus.swdio_o, bus.swdio_oe, bus.swclk_en, bus.done, bus.err}), 8'd0);
        rst = 1'b0;
        bus.abort = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge sck);
        chk("rst_mid_release", 8'({bus.cmd_ready, bus.swdio_oe, bus.done}), 8'b100);
        // back-to-back LINE_RESET then IDLE(4)
        issue(2'b00, 8'd0);
        run_bits(64, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'b10;
        bus.cmd_cnt = 8'd4;
        chk("b2b_done", 8'({bus.done, bus.cmd_ready}), 8'b10);
        @(negedge sck);
        chk("b2b_ready", 8'({bus.done, bus.cmd_ready, bus.swdio_oe}), 8'b010);
        @(negedge sck);
        bus.cmd_valid = 1'b0;
        run_bits(4, 2);
        fin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/swd_seq_ctrl.md
SWD_SEQ_CTRL -- requirements
Module: swd_seq_ctrl

Interface
REQ-001 SHALL have parameter LR_LEN, default 64: number of ones in each line-reset run; legal range 50-255.
REQ-002 SHALL have parameter CNT_W, default 8: width of the idle-count field.
REQ-003 SHALL have port sck  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1: command request.
REQ-006 SHALL have port cmd_ready  output  1: command accepted when valid and ready are both high at a rising edge.
REQ-007 SHALL have port cmd_op  input  2: operation; 00 LINE_RESET, 01 JTAG_TO_SWD, 10 IDLE, 11 reserved.
REQ-008 SHALL have port cmd_cnt  input  CNT_W: number of zero bits for IDLE; ignored for other ops.
REQ-009 SHALL have port abort  input  1: synchronous cancel of the current sequence.
REQ-010 SHALL have port swdio_o  output  1: serial bit to drive onto swdio.
REQ-011 SHALL have port swdio_oe  output  1: high while swdio_o is a valid sequence bit.
REQ-012 SHALL have port swclk_en  output  1: gate for swclk; equals swdio_oe.
REQ-013 SHALL have port done  output  1: one-cycle completion pulse.
REQ-014 SHALL have port err  output  1: one-cycle pulse on acceptance of a reserved op.

Function
REQ-015 SHALL implement the states IDLE, ONES1, SEQ16, ONES2, ZEROS and DONE.
REQ-016 SHALL drive cmd_ready = (state==IDLE) && !abort.
REQ-017 SHALL, on acceptance, present the first sequence bit on swdio_o with swdio_oe=1 in the next cycle, and then one bit per sck cycle with no gaps.
REQ-018 SHALL, for LINE_RESET, emit LR_LEN ones (ONES1) then go to DONE.
REQ-019 SHALL, for JTAG_TO_SWD, emit LR_LEN ones, then 16'hE79E LSB first (SEQ16), then LR_LEN ones (ONES2), then 2 zeros (ZEROS), then go to DONE; total 2*LR_LEN+18 bits.
REQ-020 SHALL, for IDLE, emit cmd_cnt zeros (ZEROS), then go to DONE.
REQ-021 SHALL treat IDLE with cmd_cnt=0 as emitting no bits: the state goes IDLE->DONE directly and done pulses in the cycle after acceptance.
REQ-022 SHALL, for op 11, pulse err in the cycle after acceptance, emit no bits, assert no done, and remain in IDLE.
REQ-023 SHALL spend exactly one cycle in DONE with done=1, swdio_oe=0 and cmd_ready=0, then return to IDLE.
REQ-024 SHALL hold swdio_o=0 whenever swdio_oe=0.
REQ-025 SHALL use a single bit counter wide enough for max(LR_LEN, 2^CNT_W-1), loaded on each state entry and decremented per emitted bit; the state advances when the counter reaches 1.
REQ-026 SHALL capture cmd_op and cmd_cnt at acceptance, so later input changes have no effect on the running sequence.
REQ-027 SHALL, when abort is high in any non-IDLE state, go to IDLE at the next edge with swdio_oe=0 and no done or err pulse.
REQ-028 SHALL, when abort and cmd_valid are both high in IDLE, not accept the command.
REQ-029 SHALL not accept a command during a sequence or in DONE; the earliest back-to-back acceptance is the cycle after the DONE cycle.

Reset
REQ-030 SHALL, while rst is high at an edge, enter IDLE with swdio_o=0, swdio_oe=0, swclk_en=0, done=0, err=0 and the counter cleared.
REQ-031 SHALL have rst override abort and cmd_valid, including reset mid-sequence, with no done pulse.
REQ-032 SHALL have cmd_ready=1 in the first cycle after rst deasserts, provided abort is low.

Verification
REQ-033 SHALL cover: LINE_RESET with LR_LEN=64 -> exactly 64 consecutive cycles with swdio_oe=1 and swdio_o=1, then done high for 1 cycle.
REQ-034 SHALL cover: JTAG_TO_SWD -> 146 bits: 64 ones; then 0,1,1,1,1,0,0,1,1,1,1,0,0,1,1,1; then 64 ones; then 0,0; then done.
REQ-035 SHALL cover: IDLE with cmd_cnt=50 -> 50 zero bits with oe=1, then done; IDLE with cmd_cnt=0 -> no oe cycles, done in the cycle after acceptance.
REQ-036 SHALL cover: op 11 -> err pulse 1 cycle, no oe, no done, cmd_ready stays 1.
REQ-037 SHALL cover: abort at bit 20 of JTAG_TO_SWD -> oe low next cycle, no done; abort held with cmd_valid in IDLE -> no acceptance.
REQ-038 SHALL cover: rst asserted at bit 30 of LINE_RESET -> all outputs 0 next cycle; back-to-back LINE_RESET then IDLE(4) -> IDLE accepted the cycle after the done cycle.
